regfile_scoreboard_2r1w: RTL and testbench
==========================================

Name: regfile_scoreboard_2r1w

Overview:
Parametrised ID-stage register file with two asynchronous read ports and one synchronous write port.
Successor to the fixed 32x32 file. Adds configurable width and depth, an optional hard-wired zero register, and a per-register pending-write scoreboard.
The scoreboard lets ID detect RAW hazards against in-flight instructions. Issue sets a register's pending bit; writeback clears it.
Sits between IF/ID pipeline register and ID/EX; WB stage drives the write port.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (localparam, not overridable)
ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never marked pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
rd_addr_a  in  ADDR_W  read port A address (rs)
rd_data_a  out  DATA_W  read port A data
rd_addr_b  in  ADDR_W  read port B address (rt)
rd_data_b  out  DATA_W  read port B data
iss_en  in  1  instruction leaving ID with a destination register
iss_addr  in  ADDR_W  that instruction's destination
flush  in  1  pipeline flush; clears all pending bits
busy_a  out  1  register at rd_addr_a has a pending write
busy_b  out  1  register at rd_addr_b has a pending write
any_busy  out  1  OR of all pending bits (drain detect)

Behaviour:
- Reset (rst_n low, asynchronous): all registers become 0 and all pending bits become 0. While in reset, rd_data_a/b = 0, busy_a/b = 0, any_busy = 0.
- Write: at a rising edge with wr_en = 1, regs[wr_addr] <= wr_data. When ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read: combinational, zero latency. rd_data = regs[rd_addr]. When ZERO_REG = 1 and rd_addr = 0, data is 0 regardless of stored contents.
- Pending bits, next-state priority per register r:
  1. flush -> 0
  2. iss_en and iss_addr == r -> 1
  3. wr_en and wr_addr == r -> 0
  4. otherwise hold
- Simultaneous issue and writeback to the same register: set wins. The new producer is still outstanding.
- flush has precedence over a same-cycle iss_en. A same-cycle wr_en still updates data.
- ZERO_REG = 1: pending[0] is tied to 0; an issue to r0 is ignored.
- Writeback to a non-pending register: data is written; the pending bit stays 0. Not an error.
- Re-issue to an already-pending register: the bit stays 1. There is no count; the youngest writer is the one that clears it.
- busy_x = pending[rd_addr_x], subject to the bypass rule below.
- any_busy is registered-state only, with no bypass. It is 0 during and immediately after reset.
- Port A and port B reading the same address are independent and return identical results.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined: same-cycle write-through. If wr_en = 1 and wr_addr == rd_addr_x (excluding r0 when ZERO_REG = 1), then rd_data_x = wr_data and busy_x = 0 in that cycle.
- Exception: if iss_en also targets that address, busy_x stays 1.
- Undefined: reads return the pre-edge stored value and busy_x reflects the registered pending bit. The write becomes visible on the cycle after the edge.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants
  - typedef reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits)
  - localparam ZERO_ADDR = 0
- One sub-module is natural: regfile_pending_sb.
  - Holds the NUM_REGS pending vector.
  - Inputs: set/clear/flush.
  - Outputs: vector plus any_busy.
  - The top instantiates it and does the read muxing and bypass.

Test Plan:
- Reset with rst_n low mid-cycle: after writing 0xDEADBEEF to r5, assert rst_n = 0 asynchronously -> rd_data_a(r5) = 0 immediately, any_busy = 0.
- Write 0x12345678 to r7, read r7 on A and B in the same cycle -> without bypass: old value 0, then 0x12345678 next cycle; with bypass: 0x12345678 in the same cycle.
- ZERO_REG = 1: write 0xFFFFFFFF to r0 and issue to r0 -> rd_data_a(r0) = 0, busy_a = 0, any_busy = 0.
- Issue to r3, then two idle cycles -> busy_a(r3) = 1 and any_busy = 1; writeback r3 = 0xA5 -> busy clears on the next cycle (or the same cycle under bypass).
- Same-cycle iss_en and wr_en both targeting r9 (r9 already pending) -> r9 data updated, pending[9] stays 1.
- Issue to r1, r2 and r31, then assert flush together with iss_en to r4 -> all pending bits 0, any_busy = 0 on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2R1W register file with pending-write scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_pending_sb.sv
// Per-register pending-write scoreboard: issue sets, writeback clears, flush clears all.
module regfile_pending_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    input  logic                   flush,
    output logic [(2**ADDR_W)-1:0] pending,
    output logic                   any_busy
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic                any_busy_r;

    // Next-state per register: flush beats issue, issue beats writeback, else hold.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((ZERO_REG != 0) && (r == ZERO_ADDR)) begin
                pending_nxt_s[r] = 1'b0;
            end else if (flush) begin
                pending_nxt_s[r] = 1'b0;
            end else if (set_en && (set_addr == ADDR_W'(r))) begin
                pending_nxt_s[r] = 1'b1;
            end else if (clr_en && (clr_addr == ADDR_W'(r))) begin
                pending_nxt_s[r] = 1'b0;
            end else begin
                pending_nxt_s[r] = pending_r[r];
            end
        end
    end

    // Pending state and its OR-reduction, both held in flops so any_busy never sees bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= {NUM_REGS{1'b0}};
            any_busy_r <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            any_busy_r <= |pending_nxt_s;
        end
    end

    assign pending  = pending_r;
    assign any_busy = any_busy_r;

endmodule

// File: rtl/regfile_scoreboard_2r1w.sv
// ID-stage register file, two async reads, one sync write, with RAW scoreboard.
// Optional same-cycle write-through selected by macro REGFILE_WB_BYPASS_EN.
module regfile_scoreboard_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] pending_s;
    logic                wr_ok_s;
    logic                zero_a_s;
    logic                zero_b_s;
    logic                byp_a_s;
    logic                byp_b_s;
    logic                iss_hit_a_s;
    logic                iss_hit_b_s;

    assign wr_ok_s  = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_A));
    assign zero_a_s = (ZERO_REG != 0) && (rd_addr_a == ZERO_A);
    assign zero_b_s = (ZERO_REG != 0) && (rd_addr_b == ZERO_A);

`ifdef REGFILE_WB_BYPASS_EN
    // Write-through is suppressed in reset so outputs read zero while rst_n is low.
    assign byp_a_s     = rst_n && wr_ok_s && (wr_addr == rd_addr_a);
    assign byp_b_s     = rst_n && wr_ok_s && (wr_addr == rd_addr_b);
    assign iss_hit_a_s = iss_en && (iss_addr == rd_addr_a);
    assign iss_hit_b_s = iss_en && (iss_addr == rd_addr_b);
`else
    assign byp_a_s     = 1'b0;
    assign byp_b_s     = 1'b0;
    assign iss_hit_a_s = 1'b0;
    assign iss_hit_b_s = 1'b0;
`endif

    // Register array storage with async clear; r0 writes are dropped when hard-wired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    regfile_pending_sb #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pending_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_en),
        .set_addr (iss_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .flush    (flush),
        .pending  (pending_s),
        .any_busy (any_busy)
    );

    // Port A read mux; a same-cycle issue to the bypassed register keeps it busy.
    always_comb begin
        if (zero_a_s) begin
            rd_data_a = {DATA_W{1'b0}};
            busy_a    = 1'b0;
        end else if (byp_a_s) begin
            rd_data_a = wr_data;
            busy_a    = pending_s[rd_addr_a] & iss_hit_a_s;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
            busy_a    = pending_s[rd_addr_a];
        end
    end

    // Port B read mux, identical to port A.
    always_comb begin
        if (zero_b_s) begin
            rd_data_b = {DATA_W{1'b0}};
            busy_b    = 1'b0;
        end else if (byp_b_s) begin
            rd_data_b = wr_data;
            busy_b    = pending_s[rd_addr_b] & iss_hit_b_s;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
            busy_b    = pending_s[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard_2r1w.sv
// Directed table-driven bench for regfile_scoreboard_2r1w plus hand-written corner sequences.
module tb_regfile_scoreboard_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic        busy_a;
    logic        busy_b;
    logic        any_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        flush;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_busy_b;
        logic        exp_any;
    } vec_t;

    vec_t vecs [9];

    regfile_scoreboard_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .any_busy  (any_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic ie, input logic [4:0] ia, input logic fl);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        iss_en = ie; iss_addr = ia; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // wr_en, wr_addr, wr_data, ra, rb, iss_en, iss_addr, flush, exp_a, exp_b, busy_a, busy_b, any
        vecs[0] = '{1'b1, 5'd1, 32'h0000_0011, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd2, 32'h0000_0022, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 32'h22, 32'h11, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h11, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd3, 32'h0000_00A5, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd0, 1'b0, 32'hA5, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 5'd4, 32'h0000_0044, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0, 32'hA5, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].ra, vecs[i].rb,
                  vecs[i].iss_en, vecs[i].iss_addr, vecs[i].flush);
            @(negedge clk);
            check($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
            check($sformatf("vec%0d busy_a", i), {31'd0, busy_a}, {31'd0, vecs[i].exp_busy_a});
            check($sformatf("vec%0d busy_b", i), {31'd0, busy_b}, {31'd0, vecs[i].exp_busy_b});
            check($sformatf("vec%0d any_busy", i), {31'd0, any_busy}, {31'd0, vecs[i].exp_any});
            next_cycle();
        end

        // Same-cycle write and read of r7 on both ports.
        drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
        check("r7 same-cycle a", rd_data_a, 32'h1234_5678);
        check("r7 same-cycle b", rd_data_b, 32'h1234_5678);
`else
        check("r7 same-cycle a", rd_data_a, 32'h0);
        check("r7 same-cycle b", rd_data_b, 32'h0);
`endif
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("r7 next-cycle a", rd_data_a, 32'h1234_5678);
        check("r7 next-cycle b", rd_data_b, 32'h1234_5678);
        next_cycle();

        // r9 pending, then issue and writeback to r9 in the same cycle: set wins.
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        next_cycle();
        drive(1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        check("r9 iss+wr busy_a", {31'd0, busy_a}, 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
        check("r9 iss+wr data", rd_data_a, 32'h99);
`else
        check("r9 iss+wr data", rd_data_a, 32'h0);
`endif
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("r9 after data", rd_data_a, 32'h99);
        check("r9 after busy_b", {31'd0, busy_b}, 32'd1);
        check("r9 after any_busy", {31'd0, any_busy}, 32'd1);
        next_cycle();
        drive(1'b1, 5'd9, 32'h0000_0999, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("r9 cleared busy_a", {31'd0, busy_a}, 32'd0);
        check("r9 cleared data", rd_data_a, 32'h999);
        check("r9 cleared any_busy", {31'd0, any_busy}, 32'd0);
        next_cycle();

        // Issue r1, r2, r31; flush together with issue to r4.
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd31, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd1, 1'b1, 5'd4, 1'b1);
        @(negedge clk);
        check("flush cyc busy_a r4", {31'd0, busy_a}, 32'd0);
        check("flush cyc busy_b r1", {31'd0, busy_b}, 32'd1);
        check("flush cyc any_busy", {31'd0, any_busy}, 32'd1);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd31, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("post-flush busy_a r4", {31'd0, busy_a}, 32'd0);
        check("post-flush busy_b r31", {31'd0, busy_b}, 32'd0);
        check("post-flush any_busy", {31'd0, any_busy}, 32'd0);
        next_cycle();

        // Async reset in mid-cycle after writing r5 with r6 pending.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("pre-reset r5", rd_data_a, 32'hDEAD_BEEF);
        check("pre-reset busy_b r6", {31'd0, busy_b}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("in-reset r5", rd_data_a, 32'h0);
        check("in-reset busy_b", {31'd0, busy_b}, 32'd0);
        check("in-reset any_busy", {31'd0, any_busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset r5", rd_data_a, 32'h0);
        check("post-reset any_busy", {31'd0, any_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
